mdu_sequencer: RTL

Iterative sequencer for RV32M multiply/divide operations, placed beside the main ALU in the EX stage. It accepts one M-extension operation at a time, runs a 32-step shift-add multiply or restoring divide, and applies sign correction. While it works it holds `busy` so hazard logic stalls the pipeline. It returns a registered result with a single-cycle `done` pulse.

---
 rtl/mdu_sequencer_if.sv | 24 ++
 rtl/mdu_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
// The pipeline side is the master; the sequencer itself is the slave.
interface mdu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (
    output start, flush, Funct3, SrcA, SrcB,
    input  busy, done, Result
  );

  modport slave (
    input  start, flush, Funct3, SrcA, SrcB,
    output busy, done, Result
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M sequencer: shift-add multiply and restoring divide on operand
// magnitudes, followed by a two's-complement sign fix-up.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  mdu_sequencer_if.slave   bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [2:0]        op;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo;
  logic [CW-1:0]     cnt;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic              in_signed_a;
  logic              in_signed_b;
  logic              in_neg_a;
  logic              in_neg_b;
  logic [XLEN-1:0]   in_mag_a;
  logic [XLEN-1:0]   in_mag_b;
  logic              in_div_zero;
  logic              in_overflow;
  logic [XLEN-1:0]   special_result;

  // Decode the incoming request: signedness, magnitudes and the shortcut cases.
  always_comb begin
    in_signed_a    = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                     (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    in_signed_b    = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) ||
                     (bus.Funct3 == 3'b110);
    in_neg_a       = in_signed_a && bus.SrcA[XLEN-1];
    in_neg_b       = in_signed_b && bus.SrcB[XLEN-1];
    in_mag_a       = in_neg_a ? -bus.SrcA : bus.SrcA;
    in_mag_b       = in_neg_b ? -bus.SrcB : bus.SrcB;
    in_div_zero    = bus.Funct3[2] && (bus.SrcB == '0);
    in_overflow    = bus.Funct3[2] && !bus.Funct3[0] &&
                     (bus.SrcA == MOST_NEG) && (bus.SrcB == '1);
    special_result = '1;
    if (in_div_zero) begin
      special_result = bus.Funct3[1] ? bus.SrcA : '1;
    end else if (in_overflow) begin
      special_result = bus.Funct3[1] ? '0 : MOST_NEG;
    end
  end

  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_neg;
  logic              neg_result;
  logic [XLEN-1:0]   fix_result;
  logic              rem_unused;

  // Per-step datapath and the final sign correction selected by the operation.
  always_comb begin
    add_sum    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
    div_shift  = {rem[XLEN-1:0], quo[XLEN-1]};
    div_trial  = div_shift - {1'b0, mag_b};
    prod_neg   = -prod;
    neg_result = sign_a ^ sign_b;
    rem_unused = rem[XLEN];
    fix_result = '0;
    case (op)
      3'b000:         fix_result = neg_result ? prod_neg[XLEN-1:0] : prod[XLEN-1:0];
      3'b001, 3'b010: fix_result = neg_result ? prod_neg[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
      3'b011:         fix_result = prod[2*XLEN-1:XLEN];
      3'b100:         fix_result = neg_result ? -quo : quo;
      3'b101:         fix_result = quo;
      3'b110:         fix_result = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
      default:        fix_result = rem[XLEN-1:0];
    endcase
  end

  // Control FSM; flush drops the operation but keeps the last Result visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      op       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            op     <= bus.Funct3;
            sign_a <= in_neg_a;
            sign_b <= in_neg_b;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            prod   <= {{XLEN{1'b0}}, in_mag_b};
            rem    <= '0;
            quo    <= in_mag_a;
            cnt    <= '0;
            if (in_div_zero || in_overflow) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= special_result;
            end else begin
              state  <= CALC;
              busy_q <= 1'b1;
            end
          end
        end
        CALC: begin
          if (op[2]) begin
            if (!div_trial[XLEN]) begin
              rem <= div_trial;
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= div_shift;
              quo <= {quo[XLEN-2:0], 1'b0};
            end
          end else begin
            prod <= {add_sum, prod[XLEN-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_result;
          state    <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Result = result_q;
endmodule
